// File: rtl/ram_write_arbiter.sv
// Two-requester RAM write-port arbiter. Each requester has a one-word holding
// register and a base+offset address generator; a round-robin grant drains them.
module ram_write_arbiter #(
  parameter int N  = 32,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start0,
  input  logic          start1,
  input  logic [AW-1:0] base0,
  input  logic [AW-1:0] base1,
  input  logic          valid0,
  input  logic          valid1,
  input  logic [N-1:0]  data0,
  input  logic [N-1:0]  data1,
  output logic          ready0,
  output logic          ready1,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  output logic [AW-1:0] count0,
  output logic [AW-1:0] count1,
  output logic          busy
);

  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]         start_v, valid_v, full, grant, ready_v;
  logic [NUM_REQ-1:0][N-1:0]  data_v, hold;
  logic [NUM_REQ-1:0][AW-1:0] base_v, offset;
  logic                       rr_last, sel;

  assign start_v = {start1, start0};
  assign valid_v = {valid1, valid0};
  assign data_v  = {data1, data0};
  assign base_v  = {base1, base0};

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      logic          full_r;
      logic [N-1:0]  hold_r;
      logic [AW-1:0] off_r;

      // A pop and a refill in the same cycle keep the register full.
      always_ff @(posedge clk) begin
        if (reset) begin
          full_r <= 1'b0;
          hold_r <= '0;
          off_r  <= '0;
        end else begin
          if (valid_v[i] && ready_v[i]) begin
            hold_r <= data_v[i];
            full_r <= 1'b1;
          end else if (grant[i]) begin
            full_r <= 1'b0;
          end
          if (start_v[i])    off_r <= '0;
          else if (grant[i]) off_r <= off_r + AW'(1);
        end
      end

      assign full[i]    = full_r;
      assign hold[i]    = hold_r;
      assign offset[i]  = off_r;
      assign ready_v[i] = ~full_r | grant[i];
    end
  endgenerate

  // Tie goes to the requester that was not granted last.
  always_comb begin
    grant = '0;
    if (full[0] && (!full[1] || rr_last)) grant[0] = 1'b1;
    else if (full[1])                     grant[1] = 1'b1;
  end

  assign sel = grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_last <= 1'b1;
    end else begin
      wr_en <= |grant;
      if (|grant) begin
        wr_data <= hold[sel];
        wr_addr <= base_v[sel] + offset[sel];
        rr_last <= sel;
      end
    end
  end

  assign ready0 = ready_v[0];
  assign ready1 = ready_v[1];
  assign count0 = offset[0];
  assign count1 = offset[1];
  assign busy   = |full | wr_en;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed bench for ram_write_arbiter: source queues drive valid/ready,
// expected writes go into a scoreboard popped whenever wr_en is seen.
module tb_ram_write_arbiter;
  localparam int N  = 32;
  localparam int AW = 20;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic [AW-1:0] base0 = '0, base1 = '0;
  logic          valid0 = 1'b0, valid1 = 1'b0;
  logic [N-1:0]  data0 = '0, data1 = '0;
  logic          ready0, ready1, wr_en, busy;
  logic [AW-1:0] wr_addr, count0, count1;
  logic [N-1:0]  wr_data;

  int checks = 0;
  int errors = 0;

  wr_t          sb[$];
  logic [N-1:0] src0[$];
  logic [N-1:0] src1[$];
  logic         r0_s, r1_s, we_s;

  always #5 clk = ~clk;

  ram_write_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .start0(start0), .start1(start1),
    .base0(base0), .base1(base1),
    .valid0(valid0), .valid1(valid1),
    .data0(data0), .data1(data1),
    .ready0(ready0), .ready1(ready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .count0(count0), .count1(count1),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [N-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // One clock cycle: present queue heads, sample ready/wr_en mid-cycle,
  // pop on handshake, then release start pulses just after the edge.
  task automatic step();
    valid0 = (src0.size() != 0);
    data0  = valid0 ? src0[0] : N'($urandom());
    valid1 = (src1.size() != 0);
    data1  = valid1 ? src1[0] : N'($urandom());
    @(negedge clk);
    r0_s = ready0;
    r1_s = ready1;
    we_s = wr_en;
    @(posedge clk);
    if (valid0 && r0_s) void'(src0.pop_front());
    if (valid1 && r1_s) void'(src1.pop_front());
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || sb.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!reset && wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 64'(wr_en), 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] t1_we;

    // Reset state
    do_reset();
    check("rst_wr_en",   64'(wr_en),   64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_ready0",  64'(ready0),  64'd1);
    check("rst_ready1",  64'(ready1),  64'd1);
    check("rst_count0",  64'(count0),  64'd0);
    check("rst_count1",  64'(count1),  64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);

    // Lone requester 0 streaming at 1 word/cycle
    base0 = AW'(5);
    for (int i = 0; i < 4; i++) begin
      src0.push_back(N'(32'hA0 + i));
      expect_wr(AW'(5 + i), N'(32'hA0 + i));
    end
    t1_we = 7'b0111100;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t1_ready0", 64'(r0_s), 64'd1);
      check("t1_wr_en",  64'(we_s), 64'(t1_we[i]));
    end
    drain();
    check("t1_count0", 64'(count0), 64'd4);

    // Contention: strict alternation starting with requester 0
    do_reset();
    base0 = AW'(5);
    base1 = AW'(10);
    for (int i = 0; i < 3; i++) begin
      src0.push_back(N'(32'hB0 + i));
      src1.push_back(N'(32'hC0 + i));
      expect_wr(AW'(5 + i),  N'(32'hB0 + i));
      expect_wr(AW'(10 + i), N'(32'hC0 + i));
    end
    step();
    check("t2_c0_ready0", 64'(r0_s), 64'd1);
    check("t2_c0_ready1", 64'(r1_s), 64'd1);
    step();
    check("t2_c1_ready0", 64'(r0_s), 64'd1);
    check("t2_c1_ready1", 64'(r1_s), 64'd0);
    step();
    check("t2_c2_ready0", 64'(r0_s), 64'd0);
    check("t2_c2_ready1", 64'(r1_s), 64'd1);
    drain();
    check("t2_count0", 64'(count0), 64'd3);
    check("t2_count1", 64'(count1), 64'd3);

    // Requester 1 alone, then a tie: requester 0 wins first
    src1.push_back(N'(32'hD0));
    expect_wr(AW'(13), N'(32'hD0));
    drain();
    src0.push_back(N'(32'hE0));
    src1.push_back(N'(32'hD1));
    expect_wr(AW'(8),  N'(32'hE0));
    expect_wr(AW'(14), N'(32'hD1));
    drain();

    // start1 restarts the offset
    base1  = AW'(0);
    start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src1.push_back(N'(32'hF0 + i));
      expect_wr(AW'(i), N'(32'hF0 + i));
    end
    drain();
    check("t4_count1_a", 64'(count1), 64'd3);
    start1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src1.push_back(N'(32'hF3 + i));
      expect_wr(AW'(i), N'(32'hF3 + i));
    end
    drain();
    check("t4_count1_b", 64'(count1), 64'd2);

    // start0 coinciding with grant0 uses the pre-start offset
    base0  = AW'(5);
    start0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      src0.push_back(N'(32'h100 + i));
      expect_wr(AW'(5 + i), N'(32'h100 + i));
    end
    drain();
    check("t5_count0_pre", 64'(count0), 64'd7);
    src0.push_back(N'(32'h107));
    expect_wr(AW'(12), N'(32'h107));
    step();
    start0 = 1'b1;
    step();
    check("t5_count0_restart", 64'(count0), 64'd0);
    src0.push_back(N'(32'h108));
    expect_wr(AW'(5), N'(32'h108));
    drain();
    check("t5_count0_post", 64'(count0), 64'd1);

    // Address wrap past 2^AW-1
    base0  = '1;
    start0 = 1'b1;
    src0.push_back(N'(32'h200));
    src0.push_back(N'(32'h201));
    expect_wr('1, N'(32'h200));
    expect_wr(AW'(0), N'(32'h201));
    drain();
    check("t6_count0", 64'(count0), 64'd2);

    // Reset while both holding registers are full
    src0.push_back(N'(32'h300));
    src1.push_back(N'(32'h301));
    step();
    check("t7_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t7_wr_en",  64'(wr_en),  64'd0);
    check("t7_busy",   64'(busy),   64'd0);
    check("t7_ready0", 64'(ready0), 64'd1);
    check("t7_ready1", 64'(ready1), 64'd1);
    step();
    check("t7_we_next", 64'(we_s),  64'd0);
    check("t7_wr_en2",  64'(wr_en), 64'd0);
    check("t7_busy2",   64'(busy),  64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
